// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state encodings, sizing constants and
// the modular index helper shared by the UART TX arbiter.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int GID_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // (base + off) mod n, for base < n and off < n
  function automatic logic [GID_W-1:0] rr_wrap(
    input logic [GID_W-1:0] base,
    input int unsigned      off,
    input int unsigned      n
  );
    int unsigned s;
    s = 32'(base) + off;
    if (s >= n) s = s - n;
    return s[GID_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at i_ptr.
// Ports: i_req, i_ptr in; o_valid, o_idx (winner) out.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [GID_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [GID_W-1:0] o_idx
);

  logic [MAX_REQ-1:0] w_req;
  logic [N-1:0]       w_rot;

  assign w_req = MAX_REQ'(i_req);

  // w_rot[k] is the request at position ptr+k (mod N)
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++)
      w_rot[k] = w_req[rr_wrap(i_ptr, k, N)];
  end

  assign o_valid = |w_rot;

  // scan downward so the smallest offset wins
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) o_idx = rr_wrap(i_ptr, k, N);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter.
// Ports: sclk, nrst, req, req_byte, tx_done in; ack, tx_trigger,
// tx_byte, busy, grant_id, err out. Macro UART_ARB_TIMEOUT_EN
// enables the WAIT watchdog (err pulse, no ack).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 10_000
) (
  input  logic                 sclk,
  input  logic                 nrst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_trigger,
  output logic [7:0]           tx_byte,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id,
  output logic                 err
);

  state_t r_state;
  state_t w_next;

  logic [GID_W-1:0]     r_ptr;
  logic [GID_W-1:0]     r_gid;
  logic [7:0]           r_byte;
  logic                 w_valid;
  logic [GID_W-1:0]     w_win;
  logic [8*MAX_REQ-1:0] w_bytes;
  logic                 w_wd_hit;
  logic                 w_abort;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_valid(w_valid),
    .o_idx  (w_win)
  );

  assign w_bytes = (8*MAX_REQ)'(req_byte);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_abort;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_wd_hit = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // abort flag is what WAIT left behind when it exited
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      r_abort <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      r_abort <= w_wd_hit && !tx_done;
    end
  end

  assign w_abort = r_abort;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC != 0);
  assign w_wd_hit    = 1'b0;
  assign w_abort     = 1'b0;
`endif

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_valid) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_WAIT;
      ST_WAIT: if (tx_done || w_wd_hit) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      r_ptr  <= '0;
      r_gid  <= '0;
      r_byte <= '0;
    end else begin
      if (r_state == ST_IDLE && w_valid) begin
        r_gid  <= w_win;
        r_byte <= w_bytes[{w_win, 3'b000} +: 8];
      end
      // both a normal finish and an abort move past the winner
      if (r_state == ST_DONE)
        r_ptr <= rr_wrap(r_gid, 1, NUM_REQ);
    end
  end

  always_comb begin
    tx_trigger = (r_state == ST_LOAD);
    busy       = (r_state != ST_IDLE);
    err        = (r_state == ST_DONE) && w_abort;
    ack        = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (r_state == ST_DONE) && !w_abort &&
               (r_gid == GID_W'(i));
  end

  assign tx_byte  = r_byte;
  assign grant_id = r_gid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: arbiter plus UART TX/RX loopback model,
// scoreboard of grants, bytes on the wire and acks.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int TO  = 100;
  localparam int CPB = 434;
  localparam int BUD = 30000;

  logic            sclk = 1'b0;
  logic            nrst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic            tx_done = 1'b0;
  logic [NR-1:0]   ack;
  logic            tx_trigger;
  logic [7:0]      tx_byte;
  logic            busy;
  logic [2:0]      grant_id;
  logic            err;

  always #10 sclk = ~sclk;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .TIMEOUT_CYC(TO)
  ) dut (
    .sclk      (sclk),
    .nrst      (nrst),
    .req       (req),
    .req_byte  (req_byte),
    .ack       (ack),
    .tx_trigger(tx_trigger),
    .tx_byte   (tx_byte),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err)
  );

  int n_chk  = 0;
  int n_err  = 0;
  int n_trig = 0;
  int n_ack  = 0;
  int n_errp = 0;

  logic [7:0]    q_gid[$];
  logic [7:0]    q_txb[$];
  logic [7:0]    q_rx[$];
  logic [NR-1:0] q_ack[$];

  logic line = 1'b1;
  logic u_busy = 1'b0;
  logic supp = 1'b0;
  logic r_done_seen = 1'b0;
  logic r_prev_trig = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge sclk) r_done_seen <= tx_done;

  // monitor: grants, acks and err pulses
  always @(negedge sclk) begin
    if (tx_trigger) begin
      chk("trig_pulse", 32'(r_prev_trig), 0);
      chk("gid_q", 32'(q_gid.size() != 0), 1);
      if (q_gid.size() != 0) begin
        chk("gid", 32'(grant_id), 32'(q_gid.pop_front()));
        chk("txb", 32'(tx_byte), 32'(q_txb.pop_front()));
      end
      n_trig++;
    end
    if (ack != '0) begin
      chk("ack_lat", 32'(r_done_seen), 1);
      chk("ack_q", 32'(q_ack.size() != 0), 1);
      if (q_ack.size() != 0)
        chk("ack", 32'(ack), 32'(q_ack.pop_front()));
      n_ack++;
    end
    if (err) n_errp++;
    r_prev_trig = tx_trigger;
  end

  // UART transmitter model
  always begin
    logic [7:0] b;
    @(negedge sclk);
    if (tx_trigger && !supp) begin
      b = tx_byte;
      u_busy = 1'b1;
      line <= 1'b0;
      repeat (CPB) @(negedge sclk);
      for (int i = 0; i < 8; i++) begin
        line <= b[i];
        repeat (CPB) @(negedge sclk);
      end
      line <= 1'b1;
      repeat (CPB) @(negedge sclk);
      tx_done = 1'b1;
      @(negedge sclk);
      tx_done = 1'b0;
      u_busy = 1'b0;
    end
  end

  // UART receiver on the looped-back line
  always begin
    logic [7:0] rb;
    @(negedge sclk);
    if (line == 1'b0) begin
      rb = '0;
      repeat (CPB / 2) @(negedge sclk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge sclk);
        rb[i] = line;
      end
      repeat (CPB) @(negedge sclk);
      chk("rx_stop", 32'(line), 1);
      chk("rx_q", 32'(q_rx.size() != 0), 1);
      if (q_rx.size() != 0)
        chk("rx_byte", 32'(rb), 32'(q_rx.pop_front()));
    end
  end

  task automatic push(input logic [7:0] g, input logic [7:0] b,
                      input logic do_ack);
    q_gid.push_back(g);
    q_txb.push_back(b);
    q_rx.push_back(b);
    if (do_ack) q_ack.push_back(NR'(1) << g);
  endtask

  task automatic wait_trig(input int tgt);
    int t = 0;
    while (n_trig < tgt && t < BUD) begin
      @(negedge sclk);
      t++;
    end
    chk("trig_to", 32'(n_trig >= tgt), 1);
  endtask

  task automatic wait_ack(input int tgt);
    int t = 0;
    while (n_ack < tgt && t < BUD) begin
      @(negedge sclk);
      t++;
    end
    chk("ack_to", 32'(n_ack >= tgt), 1);
    repeat (5) @(negedge sclk);
  endtask

  task automatic do_rst();
    @(negedge sclk);
    nrst = 1'b0;
    repeat (3) @(negedge sclk);
    nrst = 1'b1;
    @(negedge sclk);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_trig"}, 32'(tx_trigger), 0);
    chk({tag, "_txb"}, 32'(tx_byte), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_gid"}, 32'(grant_id), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  function automatic int qsz();
    return q_gid.size() + q_txb.size() + q_rx.size() + q_ack.size();
  endfunction

  initial begin
    repeat (90000) @(negedge sclk);
    $display("FAIL watchdog sim_time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int a0;
    int lat;

    repeat (3) @(negedge sclk);
    chk_rst("rst");
    nrst = 1'b1;
    @(negedge sclk);

    // single requester, latency and one-cycle trigger
    req_byte[7:0] = 8'h3A;
    push(0, 8'h3A, 1'b1);
    req = 4'b0001;
    @(negedge sclk);
    chk("s1_lat", 32'(tx_trigger), 1);
    @(negedge sclk);
    chk("s1_pulse", 32'(tx_trigger), 0);
    chk("s1_busy", 32'(busy), 1);
    req = '0;
    wait_ack(1);
    chk("s1_idle", 32'(busy), 0);
    chk("s1_q", 32'(qsz()), 0);

    // all four held: 0,1,2,3,0
    do_rst();
    req_byte = {8'h44, 8'h33, 8'h22, 8'h11};
    push(0, 8'h11, 1'b1);
    push(1, 8'h22, 1'b1);
    push(2, 8'h33, 1'b1);
    push(3, 8'h44, 1'b1);
    push(0, 8'h11, 1'b1);
    t0 = n_trig;
    a0 = n_ack;
    req = 4'b1111;
    wait_trig(t0 + 5);
    req = '0;
    wait_ack(a0 + 5);
    chk("s2_q", 32'(qsz()), 0);

    // ptr moved to 2, then 0011 wraps to 0, then 1
    req_byte = {8'h00, 8'h00, 8'hB1, 8'hA0};
    push(1, 8'hB1, 1'b1);
    push(0, 8'hA0, 1'b1);
    push(1, 8'hB1, 1'b1);
    t0 = n_trig;
    a0 = n_ack;
    req = 4'b0010;
    wait_trig(t0 + 1);
    req = 4'b0011;
    wait_trig(t0 + 3);
    req = '0;
    wait_ack(a0 + 3);
    chk("s3_q", 32'(qsz()), 0);

    // req dropped one cycle after LOAD
    req_byte[15:8] = 8'h5C;
    push(1, 8'h5C, 1'b1);
    a0 = n_ack;
    req = 4'b0010;
    lat = 0;
    while (!tx_trigger && lat < 10) begin
      @(negedge sclk);
      lat++;
    end
    chk("s4_trig", 32'(tx_trigger), 1);
    @(negedge sclk);
    req = '0;
    wait_ack(a0 + 1);
    chk("s4_q", 32'(qsz()), 0);

    // reset mid-WAIT, stale tx_done later
    req_byte[23:16] = 8'h77;
    push(2, 8'h77, 1'b0);
    t0 = n_trig;
    a0 = n_ack;
    req = 4'b0100;
    wait_trig(t0 + 1);
    req = '0;
    repeat (2000) @(negedge sclk);
    chk("s5_wait", 32'(busy), 1);
    nrst = 1'b0;
    #1;
    chk_rst("s5");
    repeat (3) @(negedge sclk);
    nrst = 1'b1;
    lat = 0;
    while (u_busy && lat < BUD) begin
      @(negedge sclk);
      lat++;
    end
    chk("s5_uart_to", 32'(u_busy), 0);
    repeat (5) @(negedge sclk);
    chk("s5_noack", 32'(n_ack), 32'(a0));
    chk("s5_idle", 32'(busy), 0);
    chk("s5_q", 32'(qsz()), 0);

`ifdef UART_ARB_TIMEOUT_EN
    // watchdog: tx_done never arrives
    supp = 1'b1;
    req_byte[15:0] = {8'hC1, 8'hC0};
    q_gid.push_back(8'd0);
    q_txb.push_back(8'hC0);
    q_gid.push_back(8'd1);
    q_txb.push_back(8'hC1);
    t0 = n_trig;
    a0 = n_ack;
    req = 4'b0011;
    lat = 0;
    while (!tx_trigger && lat < 10) begin
      @(negedge sclk);
      lat++;
    end
    chk("to_trig", 32'(tx_trigger), 1);
    lat = 0;
    while (!err && lat < 500) begin
      @(negedge sclk);
      lat++;
    end
    chk("to_lat", 32'(lat), 32'(TO + 1));
    wait_trig(t0 + 2);
    req = '0;
    lat = 0;
    while (n_errp < 2 && lat < 500) begin
      @(negedge sclk);
      lat++;
    end
    repeat (5) @(negedge sclk);
    chk("to_noack", 32'(n_ack), 32'(a0));
    chk("to_idle", 32'(busy), 0);
    chk("to_errs", 32'(n_errp), 2);
    chk("to_q", 32'(qsz()), 0);
    supp = 1'b0;
`else
    chk("no_err", 32'(n_errp), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
